// File: rtl/trackball_quad_decoder.sv
// trackball_quad_decoder
//
// Receiving end of the trackball clk/dir step interface. It rebuilds the
// free-running per-axis position counters that the game CPU reads from its
// trackball input port, from the (h_clk,h_dir) and (v_clk,v_dir) step pulses.
//
// Each raw input goes through a 2-FF synchroniser on every clk. It is then
// glitch-filtered on ce: a level is accepted only after it has held for FILT
// consecutive ce samples. A rising edge of a filtered step clock moves that
// axis counter by one step.
//
// Ports
//   clk        core clock, all state on the rising edge
//   reset_n    asynchronous assert, active-low reset
//   ce         sample enable for the filters and counters
//   flip       cocktail flip: inverts count direction on both axes
//   h_clk      horizontal step clock (asynchronous to clk)
//   h_dir      horizontal direction, 1 = decrement
//   v_clk      vertical step clock (asynchronous to clk)
//   v_dir      vertical direction, 1 = decrement
//   sel        read select: 0 = horizontal, 1 = vertical
//   rd_strobe  one-clk read request (not gated by ce)
//   rd_data    latched counter value of the selected axis
//   h_dir_o    post-flip direction of the last accepted horizontal step
//   v_dir_o    post-flip direction of the last accepted vertical step
//   step_o     one-clk pulse {v,h} for each accepted step
module trackball_quad_decoder #(
    parameter int CNT_W = 4,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             flip,
    input  logic             h_clk,
    input  logic             h_dir,
    input  logic             v_clk,
    input  logic             v_dir,
    input  logic             sel,
    input  logic             rd_strobe,
    output logic [CNT_W-1:0] rd_data,
    output logic             h_dir_o,
    output logic             v_dir_o,
    output logic [1:0]       step_o
);

    localparam int RUN_W = 4;

    // Bit order is {v_dir, v_clk, h_dir, h_clk}.
    // For axis gi, the step clock is bit 2*gi and the direction is bit 2*gi+1.
    logic [3:0]       raw_in;
    logic [3:0]       filt_lvl;
    logic [CNT_W-1:0] cnt_lvl [2];
    logic [1:0]       dir_lvl;
    logic [1:0]       step_lvl;

    assign raw_in = {v_dir, v_clk, h_dir, h_clk};

    genvar gi;

    // Synchroniser and run-length glitch filter for each raw input.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_filt
            logic             sync1_reg;
            logic             sync2_reg;
            logic             filt_reg;
            logic [RUN_W-1:0] run_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    filt_reg  <= 1'b0;
                    run_reg   <= '0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    if (ce) begin
                        if (sync2_reg != filt_reg) begin
                            // This is the FILT-th consecutive differing sample,
                            // so the new level is accepted now.
                            if (run_reg == RUN_W'(FILT - 1)) begin
                                filt_reg <= sync2_reg;
                                run_reg  <= '0;
                            end else begin
                                run_reg <= run_reg + 1'b1;
                            end
                        end else begin
                            run_reg <= '0;
                        end
                    end
                end
            end

            assign filt_lvl[gi] = filt_reg;
        end
    endgenerate

    // Per-axis edge detection and position counting.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic             clk_d_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             dir_reg;
            logic             step_reg;
            logic             clk_f;
            logic             dir_f;

            assign clk_f = filt_lvl[2*gi];
            assign dir_f = filt_lvl[2*gi+1];

            // The edge is taken against a delayed copy of the filtered clock.
            // That adds one clk between accepting a level and counting it.
            // dir_f is the filtered direction held before this cycle's update.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    clk_d_reg <= 1'b0;
                    cnt_reg   <= '0;
                    dir_reg   <= 1'b0;
                    step_reg  <= 1'b0;
                end else begin
                    step_reg <= 1'b0;
                    if (ce) begin
                        clk_d_reg <= clk_f;
                        if (clk_f && !clk_d_reg) begin
                            cnt_reg  <= (dir_f ^ flip) ? cnt_reg - 1'b1 : cnt_reg + 1'b1;
                            dir_reg  <= dir_f ^ flip;
                            step_reg <= 1'b1;
                        end
                    end
                end
            end

            assign cnt_lvl[gi]  = cnt_reg;
            assign dir_lvl[gi]  = dir_reg;
            assign step_lvl[gi] = step_reg;
        end
    endgenerate

    // Read latch. A step in the same clk lands after this sample, so the
    // read returns the pre-step value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_strobe) begin
            rd_data <= sel ? cnt_lvl[1] : cnt_lvl[0];
        end
    end

    assign h_dir_o = dir_lvl[0];
    assign v_dir_o = dir_lvl[1];
    assign step_o  = step_lvl;

endmodule

// File: tb/tb_trackball_quad_decoder.sv
module tb_trackball_quad_decoder;

    logic       clk;
    logic       reset_n;
    logic       ce;
    logic       flip;
    logic       h_clk;
    logic       h_dir;
    logic       v_clk;
    logic       v_dir;
    logic       sel;
    logic       rd_strobe;
    logic [3:0] rd_data;
    logic       h_dir_o;
    logic       v_dir_o;
    logic [1:0] step_o;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int h_steps    = 0;
    int v_steps    = 0;
    int rd_val;
    int base_h;
    int base_v;

    trackball_quad_decoder #(.CNT_W(4), .FILT(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .flip      (flip),
        .h_clk     (h_clk),
        .h_dir     (h_dir),
        .v_clk     (v_clk),
        .v_dir     (v_dir),
        .sel       (sel),
        .rd_strobe (rd_strobe),
        .rd_data   (rd_data),
        .h_dir_o   (h_dir_o),
        .v_dir_o   (v_dir_o),
        .step_o    (step_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted-step pulses away from the active edge.
    always @(negedge clk) begin
        if (step_o[0]) h_steps++;
        if (step_o[1]) v_steps++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got != exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_axis(input logic s, output int val);
        sel       = s;
        rd_strobe = 1'b1;
        tick(1);
        rd_strobe = 1'b0;
        val       = int'(rd_data);
    endtask

    task automatic pulse(input bit axis_v, input int hi, input int lo);
        if (axis_v) v_clk = 1'b1; else h_clk = 1'b1;
        tick(hi);
        if (axis_v) v_clk = 1'b0; else h_clk = 1'b0;
        tick(lo);
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; flip = 1'b0;
        h_clk = 1'b0; h_dir = 1'b0; v_clk = 1'b0; v_dir = 1'b0;
        sel = 1'b0; rd_strobe = 1'b0;

        // Reset with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            h_clk = ~h_clk; v_clk = ~v_clk; h_dir = ~h_dir; rd_strobe = 1'b1;
            tick(1);
        end
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_step_o", int'(step_o), 0);
        check("reset_h_dir_o", int'(h_dir_o), 0);
        check("reset_v_dir_o", int'(v_dir_o), 0);
        h_clk = 1'b0; v_clk = 1'b0; h_dir = 1'b0; rd_strobe = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(8);
        read_axis(1'b0, rd_val); check("post_reset_h", rd_val, 0);
        read_axis(1'b1, rd_val); check("post_reset_v", rd_val, 0);

        // Five horizontal increments.
        for (int i = 0; i < 5; i++) pulse(1'b0, 4, 4);
        tick(8);
        read_axis(1'b0, rd_val); check("h_5_pulses", rd_val, 5);
        check("h_step_count", h_steps, 5);

        // Vertical decrements: 3 pulses wrap below zero, then one full lap.
        v_dir = 1'b1;
        tick(8);
        for (int i = 0; i < 3; i++) pulse(1'b1, 4, 4);
        tick(8);
        read_axis(1'b1, rd_val); check("v_wrap_13", rd_val, 13);
        check("v_dir_o", int'(v_dir_o), 1);
        for (int i = 0; i < 16; i++) pulse(1'b1, 4, 4);
        tick(8);
        read_axis(1'b1, rd_val); check("v_lap_13", rd_val, 13);
        check("v_step_count", v_steps, 19);

        // Flip inverts direction.
        flip = 1'b1;
        for (int i = 0; i < 2; i++) pulse(1'b0, 4, 4);
        tick(8);
        read_axis(1'b0, rd_val); check("h_flip_3", rd_val, 3);
        check("h_dir_o_flip", int'(h_dir_o), 1);
        flip = 1'b0;
        tick(4);

        // A 1-clk glitch is rejected; a 2-clk pulse is accepted.
        base_h = h_steps;
        pulse(1'b0, 1, 10);
        check("glitch_no_step", h_steps - base_h, 0);
        read_axis(1'b0, rd_val); check("glitch_h_3", rd_val, 3);
        pulse(1'b0, 2, 8);
        check("pulse2_one_step", h_steps - base_h, 1);
        read_axis(1'b0, rd_val); check("pulse2_h_4", rd_val, 4);

        // Advance to 7, then read in the same clk as the 7->8 step.
        for (int i = 0; i < 3; i++) pulse(1'b0, 4, 4);
        tick(8);
        h_clk = 1'b1;
        tick(4);
        sel = 1'b0; rd_strobe = 1'b1;
        tick(1);
        rd_strobe = 1'b0;
        check("rd_same_clk_7", int'(rd_data), 7);
        check("step_o_h_at_latency", int'(step_o), 1);
        tick(3);
        h_clk = 1'b0;
        tick(8);
        read_axis(1'b0, rd_val); check("rd_after_8", rd_val, 8);

        // Simultaneous H increment and V decrement.
        h_clk = 1'b1; v_clk = 1'b1;
        tick(5);
        check("step_o_both", int'(step_o), 3);
        tick(3);
        h_clk = 1'b0; v_clk = 1'b0;
        tick(8);
        read_axis(1'b0, rd_val); check("both_h_9", rd_val, 9);
        read_axis(1'b1, rd_val); check("both_v_12", rd_val, 12);

        // ce low freezes filters and counters.
        base_h = h_steps;
        ce = 1'b0;
        pulse(1'b0, 4, 4);
        tick(4);
        ce = 1'b1;
        tick(8);
        check("ce_off_no_step", h_steps - base_h, 0);
        read_axis(1'b0, rd_val); check("ce_off_h_9", rd_val, 9);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
